// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit with an in-order store buffer draining into a single data-memory port.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module dmem_lsu #(
  parameter int SB_DEPTH  = 4,
  parameter int MEM_BYTES = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_mode,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_we,
  output logic [2:0]                mem_mode,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_RD, RESP} state_t;

  state_t        r_state;
  logic [2:0]    r_sb_mode [SB_DEPTH];
  logic [31:0]   r_sb_addr [SB_DEPTH];
  logic [31:0]   r_sb_data [SB_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_ld_mode;
  logic [31:0]   r_ld_addr;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic          w_half;
  logic          w_word;
  logic          w_bad_mode;
  logic          w_oob;
  logic          w_err;
  logic [2:0]    w_size;
  logic [32:0]   w_last;
  logic [31:0]   w_addr;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_next;

  // Range check uses the requested address; stores always claim a 4-byte footprint.
  always_comb begin
    w_half     = (req_mode == 3'b001) || (req_mode == 3'b100);
    w_word     = (req_mode == 3'b010);
    w_bad_mode = (req_mode > 3'b100);
    if (req_we || w_word) w_size = 3'd4;
    else if (w_half)      w_size = 3'd2;
    else                  w_size = 3'd1;
    w_last = {1'b0, req_addr} + {30'b0, w_size} - 33'd1;
    w_oob  = w_last > 33'(MEM_BYTES - 1);
    w_addr = req_addr;
    if (w_half) w_addr[0]   = 1'b0;
    if (w_word) w_addr[1:0] = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
    w_err = w_bad_mode || w_oob || (w_half && req_addr[0]) ||
            (w_word && (req_addr[1:0] != 2'b00));
`else
    w_err = w_bad_mode || w_oob;
`endif
  end

  assign req_ready  = !rst && (r_state == IDLE) && (r_count < CW'(SB_DEPTH));
  assign w_accept   = req_valid && req_ready;
  assign w_push     = w_accept && req_we && !w_err;
  assign w_pop      = !rst && (r_count != '0) && (r_state != LOAD_RD);
  assign w_cnt_next = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_sb_mode[r_wr_ptr] <= req_mode;
        r_sb_addr[r_wr_ptr] <= w_addr;
        r_sb_data[r_wr_ptr] <= req_wdata;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_cnt_next;
    end
  end

  // LOAD_RD is entered in the first cycle the buffer is empty, so a load never overlaps a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ld_mode   <= '0;
      r_ld_addr   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (req_we || w_err) begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= w_err;
              r_state     <= RESP;
            end else begin
              r_ld_mode <= req_mode;
              r_ld_addr <= w_addr;
              r_state   <= (w_cnt_next == '0) ? LOAD_RD : LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: if (w_cnt_next == '0) r_state <= LOAD_RD;
        LOAD_RD: begin
          r_rsp_rdata <= mem_rdata;
          r_rsp_err   <= 1'b0;
          r_state     <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_mode  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_pop) begin
      mem_we    = 1'b1;
      mem_mode  = r_sb_mode[r_rd_ptr];
      mem_addr  = r_sb_addr[r_rd_ptr];
      mem_wdata = r_sb_data[r_rd_ptr];
    end else if (!rst && (r_state == LOAD_RD)) begin
      mem_mode = r_ld_mode;
      mem_addr = r_ld_addr;
    end
  end

  assign rsp_valid = !rst && (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign sb_count  = r_count;
endmodule
